// File: rtl/sumu_3.sv
// sumu_3: 3-bit unsigned arithmetic leaf (add, subtract, multiply, multiply-add).
// The result and the negative flag are registered, giving one cycle of latency.
module sumu_3 #(
    localparam int unsigned OP_W  = 3,
    localparam int unsigned SEL_W = 2,
    localparam int unsigned RES_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    input  logic [SEL_W-1:0] sl,
    output logic [RES_W-1:0] c,
    output logic             neg
);

    typedef enum logic [SEL_W-1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_MAD = 2'b11
    } op_e;

    op_e              op;
    logic [RES_W-1:0] a_ext;
    logic [RES_W-1:0] b_ext;
    logic [RES_W-1:0] prod;
    logic [RES_W-1:0] c_d;
    logic [RES_W-1:0] c_q;
    logic             neg_d;
    logic             neg_q;

    assign op    = op_e'(sl);
    assign a_ext = RES_W'(a);
    assign b_ext = RES_W'(b);

    // Shift-add multiplier; 7x7 -> 7 bits is exact because 7*7 = 49 fits.
    always_comb begin
        prod = '0;
        for (int i = 0; i < int'(OP_W); i++) begin
            if (b[i]) begin
                prod = prod + (a_ext << i);
            end
        end
    end

    always_comb begin
        c_d   = '0;
        neg_d = 1'b0;
        unique case (op)
            OP_ADD: c_d = a_ext + b_ext;
            OP_SUB: begin
                c_d   = a_ext - b_ext;
                neg_d = (a < b);
            end
            OP_MUL: c_d = prod;
            OP_MAD: c_d = prod + a_ext + b_ext;
            default: c_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q   <= '0;
            neg_q <= 1'b0;
        end else begin
            c_q   <= c_d;
            neg_q <= neg_d;
        end
    end

    assign c   = c_q;
    assign neg = neg_q;

endmodule

// File: tb/tb_sumu_3.sv
// Directed bench for sumu_3: reset, each operation, boundaries, back-to-back
// select changes, mid-stream reset and hold between edges.
module tb_sumu_3;

    logic       clk;
    logic       rst;
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] sl;
    logic [6:0] c;
    logic       neg;

    int errors = 0;
    int checks = 0;

    sumu_3 dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .sl  (sl),
        .c   (c),
        .neg (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs mid-cycle, then wait for the capturing edge and settle.
    task automatic step(input logic r, input logic [2:0] av, input logic [2:0] bv,
                        input logic [1:0] sv);
        @(negedge clk);
        rst = r;
        a   = av;
        b   = bv;
        sl  = sv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 3'd7, 3'd7, 2'b11);
            checks++;
            if (c !== 7'd0) begin
                errors++;
                $display("FAIL reset_c edge%0d: got %0d want 0", k, c);
            end
            checks++;
            if (neg !== 1'b0) begin
                errors++;
                $display("FAIL reset_neg edge%0d: got %b want 0", k, neg);
            end
        end
        step(1'b0, 3'd7, 3'd7, 2'b11);
        checks++;
        if (c !== 7'd63) begin
            errors++;
            $display("FAIL reset_release_c: got %0d want 63", c);
        end
    endtask

    task automatic test_add_mul;
        step(1'b0, 3'd4, 3'd1, 2'b00);
        checks++;
        if (c !== 7'd5 || neg !== 1'b0) begin
            errors++;
            $display("FAIL add_4_1: got c=%0d neg=%b want c=5 neg=0", c, neg);
        end
        step(1'b0, 3'd4, 3'd1, 2'b10);
        checks++;
        if (c !== 7'd4 || neg !== 1'b0) begin
            errors++;
            $display("FAIL mul_4_1: got c=%0d neg=%b want c=4 neg=0", c, neg);
        end
        step(1'b0, 3'd7, 3'd7, 2'b10);
        checks++;
        if (c !== 7'd49 || neg !== 1'b0) begin
            errors++;
            $display("FAIL mul_7_7: got c=%0d neg=%b want c=49 neg=0", c, neg);
        end
        step(1'b0, 3'd7, 3'd7, 2'b00);
        checks++;
        if (c !== 7'd14 || neg !== 1'b0) begin
            errors++;
            $display("FAIL add_7_7: got c=%0d neg=%b want c=14 neg=0", c, neg);
        end
        step(1'b0, 3'd5, 3'd3, 2'b10);
        checks++;
        if (c !== 7'd15) begin
            errors++;
            $display("FAIL mul_5_3: got c=%0d want 15", c);
        end
    endtask

    task automatic test_muladd;
        step(1'b0, 3'd4, 3'd1, 2'b11);
        checks++;
        if (c !== 7'd9 || neg !== 1'b0) begin
            errors++;
            $display("FAIL mad_4_1: got c=%0d neg=%b want c=9 neg=0", c, neg);
        end
        step(1'b0, 3'd0, 3'd0, 2'b11);
        checks++;
        if (c !== 7'd0 || neg !== 1'b0) begin
            errors++;
            $display("FAIL mad_0_0: got c=%0d neg=%b want c=0 neg=0", c, neg);
        end
    endtask

    task automatic test_sub;
        step(1'b0, 3'd5, 3'd2, 2'b01);
        checks++;
        if (c !== 7'd3 || neg !== 1'b0) begin
            errors++;
            $display("FAIL sub_5_2: got c=%0d neg=%b want c=3 neg=0", c, neg);
        end
        step(1'b0, 3'd1, 3'd3, 2'b01);
        checks++;
        if (c !== 7'h7E || neg !== 1'b1) begin
            errors++;
            $display("FAIL sub_1_3: got c=%h neg=%b want c=7e neg=1", c, neg);
        end
        step(1'b0, 3'd0, 3'd7, 2'b01);
        checks++;
        if (c !== 7'h79 || neg !== 1'b1) begin
            errors++;
            $display("FAIL sub_0_7: got c=%h neg=%b want c=79 neg=1", c, neg);
        end
        step(1'b0, 3'd3, 3'd3, 2'b01);
        checks++;
        if (c !== 7'd0 || neg !== 1'b0) begin
            errors++;
            $display("FAIL sub_3_3: got c=%0d neg=%b want c=0 neg=0", c, neg);
        end
        step(1'b0, 3'd7, 3'd0, 2'b01);
        checks++;
        if (c !== 7'd7 || neg !== 1'b0) begin
            errors++;
            $display("FAIL sub_7_0: got c=%0d neg=%b want c=7 neg=0", c, neg);
        end
    endtask

    task automatic test_back_to_back;
        logic [6:0] exp_c [4];
        exp_c[0] = 7'd9;
        exp_c[1] = 7'd3;
        exp_c[2] = 7'd18;
        exp_c[3] = 7'd27;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 3'd6, 3'd3, 2'(k));
            checks++;
            if (c !== exp_c[k] || neg !== 1'b0) begin
                errors++;
                $display("FAIL b2b_sl%0d: got c=%0d neg=%b want c=%0d neg=0",
                         k, c, neg, exp_c[k]);
            end
        end
    endtask

    task automatic test_reset_mid;
        step(1'b0, 3'd4, 3'd1, 2'b11);
        checks++;
        if (c !== 7'd9) begin
            errors++;
            $display("FAIL mid_before: got %0d want 9", c);
        end
        step(1'b1, 3'd7, 3'd7, 2'b11);
        checks++;
        if (c !== 7'd0 || neg !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got c=%0d neg=%b want c=0 neg=0", c, neg);
        end
        step(1'b0, 3'd7, 3'd7, 2'b11);
        checks++;
        if (c !== 7'd63) begin
            errors++;
            $display("FAIL mid_resume: got %0d want 63", c);
        end
    endtask

    task automatic test_hold;
        step(1'b0, 3'd1, 3'd3, 2'b01);
        a  = 3'd7;
        b  = 3'd0;
        sl = 2'b00;
        #3;
        checks++;
        if (c !== 7'h7E || neg !== 1'b1) begin
            errors++;
            $display("FAIL hold_between_edges: got c=%h neg=%b want c=7e neg=1", c, neg);
        end
        @(posedge clk);
        #1;
        checks++;
        if (c !== 7'd7 || neg !== 1'b0) begin
            errors++;
            $display("FAIL hold_next_edge: got c=%0d neg=%b want c=7 neg=0", c, neg);
        end
    endtask

    initial begin
        rst = 1'b1;
        a   = 3'd0;
        b   = 3'd0;
        sl  = 2'b00;
        test_reset();
        test_add_mul();
        test_muladd();
        test_sub();
        test_back_to_back();
        test_reset_mid();
        test_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
